// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the program/data RAM arbiter: RAM geometry, rw polarity
// and the ownership state encoding.
package mem_arbiter_pkg;

    localparam int RAM_AW = 9;
    localparam int RAM_DW = 12;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_state_t;

    function automatic logic rw_of(input logic we);
        return we ? WR : RD;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port RAM.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW
);
    logic          req0;
    logic          we0;
    logic          lock0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;

    logic          req1;
    logic          we1;
    logic          lock1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvalid1;

    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rw;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  req0, we0, lock0, addr0, wdata0,
        input  req1, we1, lock1, addr1, wdata1,
        input  mem_dout,
        output gnt0, rvalid0, gnt1, rvalid1,
        output rdata, mem_addr, mem_rw, mem_din
    );

    modport master (
        output req0, we0, lock0, addr0, wdata0,
        output req1, we1, lock1, addr1, wdata1,
        output mem_dout,
        input  gnt0, rvalid0, gnt1, rvalid1,
        input  rdata, mem_addr, mem_rw, mem_din
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Two-input winner picker: round-robin on last_grant, or port 0 priority with a
// forced override for port 1. Returns a one-hot (or empty) winner vector.
module rr_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       force1,
    input  logic       fixed_mode,
    output logic [1:0] win
);

    always_comb begin
        win = req;
        if (req == 2'b11) begin
            if (fixed_mode) begin
                win = force1 ? 2'b10 : 2'b01;
            end else begin
                win = last_grant ? 2'b01 : 2'b10;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port program/data RAM: one access per
// cycle, locked sequences, 1-cycle read valid, optional starvation-guarded priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW         = RAM_AW,
    parameter int DW         = RAM_DW,
    parameter int FIXED_PRIO = 0,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rstn,
    mem_arbiter_if.slave  bus
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    own_state_t    state;
    logic          last_grant;
    logic [7:0]    starve_cnt;
    logic          rvalid0_q;
    logic          rvalid1_q;
    logic [1:0]    eligible;
    logic [1:0]    win;
    logic          force1;
    logic [AW-1:0] sel_addr;
    logic          sel_rw;
    logic [DW-1:0] sel_din;

    // An owned RAM hides the other port from the picker; reset hides both.
    always_comb begin
        eligible = 2'b00;
        if (rstn) begin
            case (state)
                FREE:    eligible = {bus.req1, bus.req0};
                OWN0:    eligible = {1'b0, bus.req0};
                OWN1:    eligible = {bus.req1, 1'b0};
                default: eligible = 2'b00;
            endcase
        end
    end

    assign force1 = (state == FREE) && (starve_cnt == STARVE_LIM);

    rr_pick u_pick (
        .req        (eligible),
        .last_grant (last_grant),
        .force1     (force1),
        .fixed_mode (FIXED_PRIO != 0),
        .win        (win)
    );

    always_comb begin
        sel_addr = bus.addr0;
        sel_rw   = RD;
        sel_din  = '0;
        if (win[1]) begin
            sel_addr = bus.addr1;
            sel_rw   = rw_of(bus.we1);
            sel_din  = bus.wdata1;
        end else if (win[0]) begin
            sel_addr = bus.addr0;
            sel_rw   = rw_of(bus.we0);
            sel_din  = bus.wdata0;
        end
    end

    assign bus.gnt0     = win[0];
    assign bus.gnt1     = win[1];
    assign bus.mem_addr = sel_addr;
    assign bus.mem_rw   = sel_rw;
    assign bus.mem_din  = sel_din;
    assign bus.rdata    = bus.mem_dout;

    // Gating with rstn drops a read valid that would land in a reset cycle.
    assign bus.rvalid0 = rvalid0_q & rstn;
    assign bus.rvalid1 = rvalid1_q & rstn;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= FREE;
            last_grant <= 1'b1;
            starve_cnt <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            rvalid0_q <= win[0] && !bus.we0;
            rvalid1_q <= win[1] && !bus.we1;
            if (|win) begin
                last_grant <= win[1];
            end
            // Saturating at the limit keeps the override armed through an OWN0 stretch.
            if (!bus.req1 || win[1]) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
            case (state)
                FREE: begin
                    if (win[0] && bus.lock0) begin
                        state <= OWN0;
                    end else if (win[1] && bus.lock1) begin
                        state <= OWN1;
                    end
                end
                OWN0: begin
                    if (!bus.lock0 && (win[0] || !bus.req0)) begin
                        state <= FREE;
                    end
                end
                OWN1: begin
                    if (!bus.lock1 && (win[1] || !bus.req1)) begin
                        state <= FREE;
                    end
                end
                default: state <= FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance, each with a RAM
// model, driven by directed and random traffic and compared against a port-level model.
module tb_mem_arbiter;

    localparam int STARVE_TB = 4;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    // Per-instance stimulus ([dut][port]); dut 0 is round-robin, dut 1 fixed priority.
    logic        req   [2][2];
    logic        we    [2][2];
    logic        lock  [2][2];
    logic [8:0]  addr  [2][2];
    logic [11:0] wdata [2][2];

    logic        gnt_o   [2][2];
    logic        rv_o    [2][2];
    logic [11:0] rdata_o [2];
    logic [8:0]  maddr_o [2];
    logic        mrw_o   [2];
    logic [11:0] mdin_o  [2];
    logic [11:0] dout    [2];

    logic [11:0] ram     [2][512];
    bit          written [2][512];

    mem_arbiter_if bus_rr ();
    mem_arbiter_if bus_fp ();

    mem_arbiter #(.FIXED_PRIO(0), .STARVE_MAX(8)) u_rr (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_rr.slave)
    );

    mem_arbiter #(.FIXED_PRIO(1), .STARVE_MAX(STARVE_TB)) u_fp (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_fp.slave)
    );

    assign bus_rr.req0 = req[0][0];     assign bus_rr.req1 = req[0][1];
    assign bus_rr.we0 = we[0][0];       assign bus_rr.we1 = we[0][1];
    assign bus_rr.lock0 = lock[0][0];   assign bus_rr.lock1 = lock[0][1];
    assign bus_rr.addr0 = addr[0][0];   assign bus_rr.addr1 = addr[0][1];
    assign bus_rr.wdata0 = wdata[0][0]; assign bus_rr.wdata1 = wdata[0][1];
    assign bus_rr.mem_dout = dout[0];
    assign bus_fp.req0 = req[1][0];     assign bus_fp.req1 = req[1][1];
    assign bus_fp.we0 = we[1][0];       assign bus_fp.we1 = we[1][1];
    assign bus_fp.lock0 = lock[1][0];   assign bus_fp.lock1 = lock[1][1];
    assign bus_fp.addr0 = addr[1][0];   assign bus_fp.addr1 = addr[1][1];
    assign bus_fp.wdata0 = wdata[1][0]; assign bus_fp.wdata1 = wdata[1][1];
    assign bus_fp.mem_dout = dout[1];

    assign gnt_o[0][0] = bus_rr.gnt0;   assign gnt_o[0][1] = bus_rr.gnt1;
    assign rv_o[0][0] = bus_rr.rvalid0; assign rv_o[0][1] = bus_rr.rvalid1;
    assign rdata_o[0] = bus_rr.rdata;   assign maddr_o[0] = bus_rr.mem_addr;
    assign mrw_o[0] = bus_rr.mem_rw;    assign mdin_o[0] = bus_rr.mem_din;
    assign gnt_o[1][0] = bus_fp.gnt0;   assign gnt_o[1][1] = bus_fp.gnt1;
    assign rv_o[1][0] = bus_fp.rvalid0; assign rv_o[1][1] = bus_fp.rvalid1;
    assign rdata_o[1] = bus_fp.rdata;   assign maddr_o[1] = bus_fp.mem_addr;
    assign mrw_o[1] = bus_fp.mem_rw;    assign mdin_o[1] = bus_fp.mem_din;

    function automatic logic [11:0] ramInit(input logic [8:0] a);
        return (a == 9'h005) ? 12'hA3C : ({a[2:0], a} ^ 12'h5A5);
    endfunction

    // Single-port RAM with registered read data, one per arbiter instance.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mrw_o[d] == 1'b0) begin
                ram[d][maddr_o[d]]     <= mdin_o[d];
                written[d][maddr_o[d]] <= 1'b1;
            end else begin
                dout[d] <= written[d][maddr_o[d]] ? ram[d][maddr_o[d]] : ramInit(maddr_o[d]);
            end
        end
    end

    // Reference model state: owner -1 means nobody holds the RAM.
    int          own      [2];
    int          last_win [2];
    int          starve   [2];
    bit          mg       [2][2];
    bit          erv      [2][2];
    logic [11:0] erd      [2];
    logic [11:0] shadow   [2][512];

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compareCycle(input int d);
        bit          c0, c1, take1;
        logic [8:0]  e_addr;
        logic        e_rw;
        logic [11:0] e_din;
        mg[d][0] = 1'b0;
        mg[d][1] = 1'b0;
        if (rstn) begin
            c0 = req[d][0] && own[d] != 1;
            c1 = req[d][1] && own[d] != 0;
            if (c0 && c1) begin
                take1 = (d == 0) ? (last_win[d] == 0) : (starve[d] == STARVE_TB);
            end else begin
                take1 = c1;
            end
            mg[d][1] = take1;
            mg[d][0] = c0 && !take1;
        end
        e_addr = addr[d][0];
        e_rw   = 1'b1;
        e_din  = 12'h000;
        for (int p = 0; p < 2; p++) begin
            if (mg[d][p]) begin
                e_addr = addr[d][p];
                e_rw   = !we[d][p];
                e_din  = wdata[d][p];
            end
        end
        checkOutput($sformatf("d%0d_gnt0", d), 32'(gnt_o[d][0]), 32'(mg[d][0]));
        checkOutput($sformatf("d%0d_gnt1", d), 32'(gnt_o[d][1]), 32'(mg[d][1]));
        checkOutput($sformatf("d%0d_rvalid0", d), 32'(rv_o[d][0]), 32'(rstn && erv[d][0]));
        checkOutput($sformatf("d%0d_rvalid1", d), 32'(rv_o[d][1]), 32'(rstn && erv[d][1]));
        checkOutput($sformatf("d%0d_mem_rw", d), 32'(mrw_o[d]), 32'(e_rw));
        checkOutput($sformatf("d%0d_mem_addr", d), 32'(maddr_o[d]), 32'(e_addr));
        checkOutput($sformatf("d%0d_mem_din", d), 32'(mdin_o[d]), 32'(e_din));
        if (rstn && (erv[d][0] || erv[d][1])) begin
            checkOutput($sformatf("d%0d_rdata", d), 32'(rdata_o[d]), 32'(erd[d]));
        end
    endtask

    task automatic advanceModel(input int d);
        if (!rstn) begin
            own[d]      = -1;
            last_win[d] = 1;
            starve[d]   = 0;
            erv[d][0]   = 1'b0;
            erv[d][1]   = 1'b0;
            return;
        end
        for (int p = 0; p < 2; p++) begin
            erv[d][p] = mg[d][p] && !we[d][p];
            if (mg[d][p]) begin
                if (we[d][p]) shadow[d][addr[d][p]] = wdata[d][p];
                else erd[d] = shadow[d][addr[d][p]];
                last_win[d] = p;
            end
        end
        if (req[d][1] && !mg[d][1]) starve[d] = (starve[d] < STARVE_TB) ? starve[d] + 1 : STARVE_TB;
        else starve[d] = 0;
        if (own[d] < 0) begin
            for (int p = 0; p < 2; p++) begin
                if (mg[d][p] && lock[d][p]) own[d] = p;
            end
        end else begin
            int o = own[d];
            if (!lock[d][o] && (mg[d][o] || !req[d][o])) own[d] = -1;
        end
    endtask

    task automatic runCycle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) compareCycle(d);
        for (int d = 0; d < 2; d++) advanceModel(d);
        @(posedge clk);
        #1;
    endtask

    task automatic setBoth(input int p, input logic r, input logic w, input logic l,
                           input logic [8:0] a, input logic [11:0] wd);
        for (int d = 0; d < 2; d++) begin
            req[d][p]   = r;
            we[d][p]    = w;
            lock[d][p]  = l;
            addr[d][p]  = a;
            wdata[d][p] = wd;
        end
    endtask

    task automatic idleAll();
        setBoth(0, 1'b0, 1'b0, 1'b0, 9'h000, 12'h000);
        setBoth(1, 1'b0, 1'b0, 1'b0, 9'h000, 12'h000);
    endtask

    // Random traffic; a pending ungranted request keeps its attributes stable.
    task automatic applyStimulus();
        rstn = ($urandom_range(0, 39) != 0);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(req[d][p] && !mg[d][p])) begin
                    req[d][p]   = ($urandom_range(0, 99) < 60);
                    we[d][p]    = ($urandom_range(0, 2) == 0);
                    lock[d][p]  = ($urandom_range(0, 4) == 0);
                    addr[d][p]  = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 15))
                                                              : 9'(9'h1F0 + $urandom_range(0, 15));
                    wdata[d][p] = 12'($urandom);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            own[d] = -1;
            last_win[d] = 1;
            starve[d] = 0;
            erd[d] = 12'h000;
            for (int p = 0; p < 2; p++) begin
                mg[d][p]  = 1'b0;
                erv[d][p] = 1'b0;
            end
            for (int i = 0; i < 512; i++) shadow[d][i] = ramInit(9'(i));
        end
        rstn = 1'b0;
        idleAll();
        runCycle();
        runCycle();

        // Read of a preloaded word right after reset release.
        rstn = 1'b1;
        setBoth(0, 1'b1, 1'b0, 1'b0, 9'h005, 12'h000);
        runCycle();
        idleAll();
        #3;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("t1_d%0d_rdata", d), 32'(rdata_o[d]), 32'h0A3C);
            checkOutput($sformatf("t1_d%0d_rvalid0", d), 32'(rv_o[d][0]), 32'd1);
        end
        runCycle();

        // Both ports reading continuously from a fresh reset.
        rstn = 1'b0;
        runCycle();
        rstn = 1'b1;
        setBoth(0, 1'b1, 1'b0, 1'b0, 9'h001, 12'h000);
        setBoth(1, 1'b1, 1'b0, 1'b0, 9'h002, 12'h000);
        #3;
        checkOutput("t2_first_gnt0", 32'(gnt_o[0][0]), 32'd1);
        repeat (6) runCycle();

        // Port 1 write then port 0 read-back of the top address.
        idleAll();
        setBoth(1, 1'b1, 1'b1, 1'b0, 9'h1FF, 12'h7FF);
        runCycle();
        idleAll();
        setBoth(0, 1'b1, 1'b0, 1'b0, 9'h1FF, 12'h000);
        runCycle();
        idleAll();
        #3;
        for (int d = 0; d < 2; d++) checkOutput($sformatf("t3_d%0d_rdata", d), 32'(rdata_o[d]), 32'h07FF);
        runCycle();

        // Port 1 locked sequence while port 0 waits.
        setBoth(1, 1'b1, 1'b0, 1'b1, 9'h010, 12'h000);
        runCycle();
        setBoth(0, 1'b1, 1'b0, 1'b0, 9'h011, 12'h000);
        runCycle();
        runCycle();
        setBoth(1, 1'b1, 1'b0, 1'b0, 9'h010, 12'h000);
        #3;
        for (int d = 0; d < 2; d++) checkOutput($sformatf("t4_d%0d_gnt0_locked", d), 32'(gnt_o[d][0]), 32'd0);
        runCycle();
        setBoth(1, 1'b0, 1'b0, 1'b0, 9'h000, 12'h000);
        #3;
        for (int d = 0; d < 2; d++) checkOutput($sformatf("t4_d%0d_gnt0_after", d), 32'(gnt_o[d][0]), 32'd1);
        runCycle();

        // Fixed priority with both ports held: starvation override on the fifth cycle.
        rstn = 1'b0;
        idleAll();
        runCycle();
        rstn = 1'b1;
        setBoth(0, 1'b1, 1'b0, 1'b0, 9'h020, 12'h000);
        setBoth(1, 1'b1, 1'b0, 1'b0, 9'h021, 12'h000);
        for (int c = 0; c < 7; c++) begin
            #3;
            checkOutput($sformatf("t5_fp_gnt1_c%0d", c), 32'(gnt_o[1][1]), 32'(c == 4));
            runCycle();
        end

        // Reset during OWN0 and right after a read grant.
        rstn = 1'b0;
        idleAll();
        runCycle();
        rstn = 1'b1;
        setBoth(0, 1'b1, 1'b0, 1'b1, 9'h003, 12'h000);
        runCycle();
        runCycle();
        rstn = 1'b0;
        #3;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("t6_d%0d_rvalid0", d), 32'(rv_o[d][0]), 32'd0);
            checkOutput($sformatf("t6_d%0d_mem_rw", d), 32'(mrw_o[d]), 32'd1);
        end
        runCycle();
        rstn = 1'b1;
        setBoth(0, 1'b0, 1'b0, 1'b0, 9'h003, 12'h000);
        setBoth(1, 1'b1, 1'b0, 1'b0, 9'h004, 12'h000);
        #3;
        for (int d = 0; d < 2; d++) checkOutput($sformatf("t6_d%0d_gnt1", d), 32'(gnt_o[d][1]), 32'd1);
        runCycle();
        idleAll();
        runCycle();

        repeat (800) begin
            applyStimulus();
            runCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter sharing the single-port 512x12 program/data RAM (genram, rw=1 read / rw=0 write, registered read data) between the Simplez CPU (port 0) and a second master (port 1, e.g. serial loader or debug monitor).
- Grants at most one access per cycle, returns read data with 1-cycle latency, and supports locked multi-access sequences.
- Sits between the CPU's addr/rw/data_in path and the RAM instance.

Parameters:
AW, 9, address width
DW, 12, data width
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 priority with starvation guard
STARVE_MAX, 8, fixed-priority mode only: consecutive denied cycles of port 1 before it is forced a grant (1..255)

Ports:
clk  in  1  system clock
rstn  in  1  synchronous reset, active-low
req0  in  1  port 0 request, held until granted
we0  in  1  port 0 write enable (1 = write)
lock0  in  1  port 0 keep ownership after this access
addr0  in  AW  port 0 address
wdata0  in  DW  port 0 write data
gnt0  out  1  port 0 access accepted this cycle (combinational)
rvalid0  out  1  port 0 read data valid on rdata
req1, we1, lock1, addr1, wdata1, gnt1, rvalid1  same as port 0, for port 1
rdata  out  DW  shared read data, equals mem_dout
mem_addr  out  AW  to RAM addr
mem_rw  out  1  to RAM rw (1 = read, 0 = write)
mem_din  out  DW  to RAM data_in
mem_dout  in  DW  from RAM data_out

Behaviour:
- Transfer occurs in any cycle where reqN && gntN. mem_addr, mem_rw = !weN and mem_din are driven combinationally from the winner in that cycle.
- No grant: mem_rw = 1, mem_addr = addr0, mem_din = 0. A spurious write is never possible.
- gnt0 && gnt1 is never 1.
- Read latency: rvalidN = 1 exactly one cycle after a granted read on port N. rdata is valid only while rvalidN = 1.
- Back-to-back grants are allowed every cycle.
- Write completes at the grant edge. No rvalid for writes.
- State machine (ownership): FREE, OWN0, OWN1.
  - FREE: arbitrate. Winner granted. If the winner's lockN = 1 at the grant, go to OWNN. Otherwise stay FREE.
  - OWNN: only port N may be granted; the other port's gnt = 0. When port N is granted with lockN = 0, return to FREE after that access.
  - OWNN with reqN = 0 and lockN = 0 returns to FREE at the next edge (abandoned lock).
- Round-robin (FIXED_PRIO=0), in FREE with both requesting: the port not granted most recently wins.
  - last_grant pointer updates on every grant.
  - Single requester always wins immediately.
- Fixed priority (FIXED_PRIO=1), port 0 wins ties, with starvation guard:
  - starve_cnt (8-bit) increments each cycle req1 = 1 and gnt1 = 0.
  - Clears on gnt1 or on req1 = 0.
  - When starve_cnt == STARVE_MAX and state is FREE, port 1 wins over port 0.
  - Saturates, never wraps.
  - starve_cnt does not force a grant while OWN0; counting continues during OWN0.
- Reset (rstn=0 at edge):
  - state = FREE, last_grant = 1 (port 0 wins the first tie), starve_cnt = 0, rvalid0 = rvalid1 = 0.
  - While rstn = 0: gnt0 = gnt1 = 0, mem_rw = 1.
  - Reset mid-lock drops ownership.
  - Reset the cycle after a read suppresses that rvalid.
- Requesters must hold addr/we/wdata stable while req is high and ungranted. The arbiter does not register them.

Decomposition:
- Shared package: state encodings FREE/OWN0/OWN1, RAM AW/DW constants (shared with the processor and genram), and rw polarity constants RD=1/WR=0.
- One sub-module is natural: rr_pick, a pure 2-input priority picker taking (req vector, last_grant, force1, fixed mode) and returning a one-hot winner.
- Ownership FSM, rvalid pipeline and starvation counter remain in mem_arbiter.

Test Plan:
1. Reset release, req0 read addr=0x005, RAM[5]=0xA3C -> gnt0 same cycle, rvalid0=1 next cycle with rdata=0xA3C, gnt1/rvalid1 stay 0.
2. RR mode, req0 and req1 continuously high (reads addr 1 and 2) -> grants alternate 0,1,0,1,... starting with port 0; never simultaneous; each rvalid follows its grant by 1 cycle.
3. Port 1 write addr=0x1FF data=0x7FF, then port 0 read 0x1FF -> mem_rw=0 only in the write-grant cycle; port 0 read returns 0x7FF.
4. Port 1 locked: lock1=1 for 3 accesses, req0 high throughout -> gnt0=0 until the access with lock1=0 completes, then gnt0=1 next cycle.
5. FIXED_PRIO=1, STARVE_MAX=4, req0 and req1 held high -> port 0 granted 4 cycles, port 1 granted on the 5th, starve_cnt cleared, port 0 resumes.
6. Assert rstn=0 during OWN0 and one cycle after a port 0 read grant -> rvalid0 suppressed, gnt=0, mem_rw=1; after release, port 1 request granted immediately (state FREE).
